// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expansion streamed over valid/ready.
// Define AES_KEYSCHED_LASTKEY_EN to add the last_key / last_key_vld capture port.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // entry a sits at byte (255-a) counting from the LSB
  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes_key_schedule #(
  parameter int OUT_WORDS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             key_len,
  input  logic [255:0]           key_in,
  output logic                   busy,
  output logic                   key_valid,
  input  logic                   key_ready,
  output logic [32*OUT_WORDS-1:0] key_data,
  output logic [5:0]             key_idx,
  output logic                   key_last,
  output logic                   done,
  output logic                   err
`ifdef AES_KEYSCHED_LASTKEY_EN
  ,
  output logic [255:0]           last_key,
  output logic                   last_key_vld
`endif
);

  localparam int CW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam logic [5:0] IDX_OFS = 6'(OUT_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]  klen;
  logic [31:0] win    [8];
  logic [31:0] win_nx [8];
  logic [5:0]  idx;
  logic [2:0]  phase;
  logic [7:0]  rcon;
  logic        gen_done;

  logic [5:0]  nk, nw;
  logic [2:0]  nk_m1;
  logic        accept, kerr;
  logic        pre, last_word;
  logic        fill, gen, shift;
  logic [CW-1:0] cnt;

  logic [31:0] prev, old, rot;
  logic [31:0] sub_in, sub_out;
  logic [31:0] t, nxt, word;
  logic [32*OUT_WORDS-1:0] beat_data;

  always_comb begin
    nk    = 6'd4;
    nw    = 6'd44;
    nk_m1 = 3'd3;
    unique case (1'b1)
      klen == 2'd1: begin
        nk    = 6'd6;
        nw    = 6'd52;
        nk_m1 = 3'd5;
      end
      klen == 2'd2: begin
        nk    = 6'd8;
        nw    = 6'd60;
        nk_m1 = 3'd7;
      end
      default: ;
    endcase
  end

  assign accept = (state == S_IDLE) && start
                  && (key_len != 2'd3);
  assign kerr   = (state == S_IDLE) && start
                  && (key_len == 2'd3);

  assign pre       = idx < nk;
  assign last_word = idx == (nw - 6'd1);
  assign fill      = cnt == CW'(OUT_WORDS - 1);
  // a beat-completing word needs the output register free or draining
  assign gen   = (state == S_RUN) && !gen_done
                 && (!fill || !key_valid || key_ready);
  assign shift = gen && !pre;

  assign prev   = win[nk_m1];
  assign old    = win[0];
  assign rot    = {prev[23:0], prev[31:24]};
  assign sub_in = (phase == 3'd0) ? rot : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a(sub_in[8*b +: 8]),
      .y(sub_out[8*b +: 8])
    );
  end

  always_comb begin
    t = prev;
    if (phase == 3'd0)
      t = sub_out ^ {rcon, 24'h0};
    else if (klen == 2'd2 && phase == 3'd4)
      t = sub_out;
  end

  assign nxt  = old ^ t;
  assign word = pre ? win[idx[2:0]] : nxt;

  // window holds w[i-Nk] at slot 0 up to w[i-1] at slot Nk-1
  always_comb begin
    for (int j = 0; j < 8; j++)
      win_nx[j] = win[j];
    if (shift) begin
      for (int j = 0; j < 7; j++)
        if (3'(j) < nk_m1)
          win_nx[j] = win[j+1];
      win_nx[nk_m1] = nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_nx = S_RUN;
      S_RUN:
        if (gen_done && key_valid && key_ready)
          state_nx = S_DONE;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  assign busy = state == S_RUN;
  assign done = state == S_DONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      klen     <= 2'd0;
      idx      <= 6'd0;
      phase    <= 3'd0;
      rcon     <= 8'h00;
      gen_done <= 1'b0;
      err      <= 1'b0;
      for (int j = 0; j < 8; j++)
        win[j] <= 32'h0;
    end else begin
      err <= kerr;
      if (accept) begin
        klen     <= key_len;
        idx      <= 6'd0;
        phase    <= 3'd0;
        rcon     <= 8'h01;
        gen_done <= 1'b0;
        for (int j = 0; j < 8; j++)
          win[j] <= key_in[255-32*j -: 32];
      end else if (gen) begin
        for (int j = 0; j < 8; j++)
          win[j] <= win_nx[j];
        idx   <= idx + 6'd1;
        phase <= (phase == nk_m1) ? 3'd0
                 : phase + 3'd1;
        if (!pre && phase == 3'd0)
          rcon <= {rcon[6:0], 1'b0}
                  ^ (rcon[7] ? 8'h1b : 8'h00);
        if (last_word)
          gen_done <= 1'b1;
      end
    end
  end

  if (OUT_WORDS == 1) begin : g_one
    assign cnt       = '0;
    assign beat_data = word;
  end else begin : g_pack
    logic [32*(OUT_WORDS-1)-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        cnt <= '0;
      end else if (gen) begin
        acc <= beat_data[32*(OUT_WORDS-1)-1:0];
        cnt <= fill ? '0 : cnt + 1'b1;
      end
    end

    assign beat_data = {acc, word};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_data  <= '0;
      key_idx   <= 6'd0;
      key_last  <= 1'b0;
    end else if (gen && fill) begin
      key_valid <= 1'b1;
      key_data  <= beat_data;
      key_idx   <= idx - IDX_OFS;
      key_last  <= last_word;
    end else if (key_ready) begin
      key_valid <= 1'b0;
    end
  end

`ifdef AES_KEYSCHED_LASTKEY_EN
  logic [255:0] lk_nx;

  always_comb begin
    lk_nx = '0;
    for (int j = 0; j < 8; j++)
      if (6'(j) < nk)
        lk_nx[255-32*j -: 32] = win[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_key     <= '0;
      last_key_vld <= 1'b0;
    end else if (accept) begin
      last_key_vld <= 1'b0;
    end else if (state == S_RUN
                 && state_nx == S_DONE) begin
      last_key     <= lk_nx;
      last_key_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: random-key and vector checks of two schedule instances
// (1 and 4 words per beat) against a GF(2^8)-derived FIPS-197 reference.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         rdy1 = 1'b1;
  logic         rdy4 = 1'b1;

  logic         busy1, v1, last1, done1, err1;
  logic [31:0]  d1;
  logic [5:0]   idx1;
  logic         busy4, v4, last4, done4, err4;
  logic [127:0] d4;
  logic [5:0]   idx4;
`ifdef AES_KEYSCHED_LASTKEY_EN
  logic [255:0] lk1, lk4;
  logic         lkv1, lkv4;
`endif

  always #5 clk = ~clk;

  aes_key_schedule #(.OUT_WORDS(1)) u_ks1 (
    .clk(clk), .rst(rst), .start(start),
    .key_len(key_len), .key_in(key_in),
    .busy(busy1), .key_valid(v1),
    .key_ready(rdy1), .key_data(d1),
    .key_idx(idx1), .key_last(last1),
    .done(done1), .err(err1)
`ifdef AES_KEYSCHED_LASTKEY_EN
    , .last_key(lk1), .last_key_vld(lkv1)
`endif
  );

  aes_key_schedule #(.OUT_WORDS(4)) u_ks4 (
    .clk(clk), .rst(rst), .start(start),
    .key_len(key_len), .key_in(key_in),
    .busy(busy4), .key_valid(v4),
    .key_ready(rdy4), .key_data(d4),
    .key_idx(idx4), .key_last(last4),
    .done(done4), .err(err4)
`ifdef AES_KEYSCHED_LASTKEY_EN
    , .last_key(lk4), .last_key_vld(lkv4)
`endif
  );

  localparam logic [255:0] K1 = {
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K2 = {
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
    64'h0};
  localparam logic [255:0] K3 = {
    128'h603deb1015ca71be2b73aef0857d7781,
    128'h1f352c073b6108d72d9810a30914dff4};

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  sb [256];
  logic [31:0] exp_w [60];
  int          exp_nw = 0;
  logic [31:0] got_w [2][60];
  int          nbeats [2];
  logic        stall_q [2];
  logic [127:0] hold_d [2];
  logic [5:0]  hold_i [2];
  logic        hold_l [2];
  logic        last_q [2];
  logic        done_seen [2];
  logic [5:0]  last_idx [2];
  bit          rand_rdy = 1'b0;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v,
                                      input int n);
    logic [15:0] dv = {v, v};
    return dv[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
              ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [1:0] len,
                        input logic [255:0] key);
    int nk;
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2 * int'(len);
    exp_nw = 4 * (nk + 7);
    for (int i = 0; i < exp_nw; i++) begin
      if (i < nk) begin
        exp_w[i] = key[255-32*i -: 32];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk == 8 && i % nk == 4) begin
          t = sub_word(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  task automatic mon(input int d, input int ow,
                     input logic v, input logic r,
                     input logic [127:0] data,
                     input logic [5:0] idx,
                     input logic lst, input logic dn);
    logic [127:0] e;
    int b;
    if (rst) begin
      stall_q[d] = 1'b0;
      last_q[d]  = 1'b0;
      return;
    end
    chk($sformatf("done%0d", ow), dn, last_q[d]);
    if (dn) done_seen[d] = 1'b1;
    last_q[d] = 1'b0;
    if (stall_q[d]) begin
      chk($sformatf("hold_v%0d", ow), v, 1);
      chk($sformatf("hold_d%0d", ow), data, hold_d[d]);
      chk($sformatf("hold_i%0d", ow), idx, hold_i[d]);
      chk($sformatf("hold_l%0d", ow), lst, hold_l[d]);
    end
    if (v && r) begin
      b = nbeats[d] * ow;
      if (b + ow > exp_nw) begin
        chk($sformatf("extra_beat%0d", ow), 1, 0);
      end else begin
        e = '0;
        for (int k = 0; k < ow; k++) begin
          e = (e << 32) | 128'(exp_w[b+k]);
          got_w[d][b+k] = data[32*(ow-1-k) +: 32];
        end
        chk($sformatf("idx%0d", ow), idx, b);
        chk($sformatf("data%0d_i%0d", ow, b), data, e);
        chk($sformatf("last%0d", ow), lst, b + ow == exp_nw);
      end
      nbeats[d]++;
      last_idx[d] = idx;
      last_q[d] = lst;
    end
    stall_q[d] = v && !r;
    hold_d[d] = data;
    hold_i[d] = idx;
    hold_l[d] = lst;
  endtask

  always @(negedge clk) begin
    mon(0, 1, v1, rdy1, {96'h0, d1}, idx1, last1, done1);
    mon(1, 4, v4, rdy4, d4, idx4, last4, done4);
  end

  always @(posedge clk) begin
    #1;
    rdy1 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    rdy4 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic start_job(input logic [1:0] len,
                           input logic [255:0] key,
                           input bit lat);
    expand(len, key);
    for (int d = 0; d < 2; d++) begin
      nbeats[d] = 0;
      done_seen[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    key_len = len;
    key_in = key;
    @(posedge clk);
    #1;
    start = 1'b0;
    key_in = ~key;
    key_len = 2'($urandom_range(0, 2));
    if (lat) begin
      for (int n = 0; n <= 4; n++) begin
        @(negedge clk);
        chk($sformatf("lat1_n%0d", n), v1, n >= 1);
        chk($sformatf("lat4_n%0d", n), v4, n >= 4);
        chk("busy_run", busy1 & busy4, 1);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!(done_seen[0] && done_seen[1]) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", done_seen[0] & done_seen[1], 1);
    chk("beats1", nbeats[0], exp_nw);
    chk("beats4", nbeats[1], exp_nw / 4);
    chk("busy_end", busy1 | busy4, 0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    start = 1'b0;
    key_len = 2'd0;
    key_in = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_v", {v1, v4, busy1, busy4}, 0);
    chk("rst_pulse", {done1, done4, err1, err4}, 0);
    chk("rst_data", {d1, d4}, 0);
    chk("rst_idx", {idx1, idx4, last1, last4}, 0);
    rst = 1'b0;

    start_job(2'd0, K1, 1);
    wait_done(2000);
    chk("t1_w4", got_w[0][4], 32'ha0fafe17);
    chk("t1_w43", got_w[0][43], 32'hb6630ca6);
    chk("t1_w43_4", got_w[1][43], 32'hb6630ca6);
`ifdef AES_KEYSCHED_LASTKEY_EN
    chk("t6_lk1", lk1, {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0});
    chk("t6_lk4", lk4, {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0});
    chk("t6_vld", {lkv1, lkv4}, 2'b11);
`endif

    start_job(2'd1, K2, 1);
    wait_done(2000);
    chk("t2_w6", got_w[0][6], 32'hfe0c91f7);
    chk("t2_w51", got_w[0][51], 32'h01002202);

    start_job(2'd2, K3, 1);
    wait_done(2000);
    chk("t3_w8", got_w[0][8], 32'h9ba35411);
    chk("t3_w59", got_w[1][59], 32'h706c631e);
    chk("t3_lastidx4", last_idx[1], 56);

    rand_rdy = 1'b1;
    start_job(2'd2, K3, 0);
    wait_done(2000);
    chk("t4_w59", got_w[0][59], 32'h706c631e);

    repeat (6) begin
      start_job(2'($urandom_range(0, 2)),
                {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()}, 0);
      wait_done(2000);
    end

    @(posedge clk);
    #1;
    start = 1'b1;
    key_len = 2'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", {err1, err4}, 2'b11);
    chk("err_busy", {busy1, busy4}, 0);
    @(negedge clk);
    chk("err_clear", {err1, err4, busy1, busy4}, 0);

    start_job(2'd1, {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), 64'h0}, 0);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    key_len = 2'd0;
    key_in = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(2000);

    rand_rdy = 1'b0;
    start_job(2'd0, K1, 0);
    c = 0;
    while (nbeats[0] < 20 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("rst_reach20", nbeats[0] >= 20, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_v", {v1, v4, busy1, busy4, done1, done4}, 0);
    chk("abort_data", {d1, d4, idx1, idx4, last1, last4}, 0);
`ifdef AES_KEYSCHED_LASTKEY_EN
    chk("abort_lkv", {lkv1, lkv4}, 0);
`endif
    rst = 1'b0;
    start_job(2'd0, K1, 1);
    wait_done(2000);
    chk("t5_w4", got_w[0][4], 32'ha0fafe17);
    chk("t5_w43", got_w[1][43], 32'hb6630ca6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
